mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 15, meaning the maximum ACCESS cycles waited for mem_ack before aborting (range 1..255).
REQ-002 The module SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The module SHALL have port start, input, 1, one-cycle request to begin a memory operation.
REQ-005 The module SHALL have port MemRead, input, 1, selects a load, sampled with start.
REQ-006 The module SHALL have port MemWrite, input, 1, selects a store, sampled with start.
REQ-007 The module SHALL have port ALUoutputVal, input, 16, the registered ALU result used as the byte address.
REQ-008 The module SHALL have port reggieOut, input, 16, the register-file data to store.
REQ-009 The module SHALL have port mem_rdata, input, 16, the read data from memory, valid when mem_ack=1.
REQ-010 The module SHALL have port mem_ack, input, 1, the memory completion handshake.
REQ-011 The module SHALL have port mem_addr, output, 16, the latched address.
REQ-012 The module SHALL have port mem_wdata, output, 16, the latched store data.
REQ-013 The module SHALL have port mem_req, output, 1, asserted throughout ACCESS.
REQ-014 The module SHALL have port mem_we, output, 1, asserted with mem_req for stores.
REQ-015 The module SHALL have port MDRout, output, 16, the memory data register holding the last load result.
REQ-016 The module SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-017 The module SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-018 The module SHALL have port err, output, 1, the sticky error flag.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS and DONE, and all outputs SHALL be registered or decoded only from state.
REQ-020 In IDLE, when start=1 with exactly one of MemRead/MemWrite high, the module SHALL latch ALUoutputVal into mem_addr, reggieOut into mem_wdata and MemWrite into mem_we, clear err and the wait counter, and go to ACCESS.
REQ-021 In IDLE, when start=1 with both MemRead and MemWrite high, the module SHALL make no memory access, set err=1 and go to DONE.
REQ-022 In IDLE, start=1 with neither MemRead nor MemWrite high SHALL be ignored, with the module remaining in IDLE.
REQ-023 mem_req SHALL be 1 exactly while in ACCESS, and mem_we SHALL be 1 only while mem_req=1 and a store is latched.
REQ-024 In ACCESS, when mem_ack=1, the module SHALL go to DONE, and for a load it SHALL load MDRout with mem_rdata on that edge.
REQ-025 In ACCESS, when mem_ack=0, the 8-bit wait counter SHALL increment; on reaching TIMEOUT the module SHALL set err=1, leave MDRout unchanged and go to DONE.
REQ-026 mem_ack=1 on the same cycle the counter reaches TIMEOUT SHALL count as success, so ack takes priority over timeout.
REQ-027 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-028 Minimum latency: start at cycle N, mem_req high at N+1, ack at N+1, done at N+2.
REQ-029 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-030 mem_ack while not in ACCESS SHALL be ignored.
REQ-031 mem_addr, mem_wdata and MDRout SHALL hold their values until the next accepted start or load, respectively.
REQ-032 Addresses SHALL be passed unmodified, with no alignment check and no wrap logic.

Reset
REQ-033 reset=1 SHALL force state to IDLE on the next edge, regardless of current state, including mid-ACCESS, and SHALL abandon the access without a done pulse.
REQ-034 Reset values SHALL be: mem_addr, mem_wdata and MDRout 16'h0000; mem_req, mem_we, busy, done and err 0; wait counter 0.
REQ-035 reset SHALL take priority over start and mem_ack on the same edge.

Verification
REQ-036 Load: ALUoutputVal=16'h0040, MemRead=1, start pulse, mem_ack on the 3rd ACCESS cycle with mem_rdata=16'hBEEF -> mem_addr=16'h0040, mem_we=0, MDRout=16'hBEEF, done one cycle, err=0.
REQ-037 Store: ALUoutputVal=16'h0102, reggieOut=16'h1234, MemWrite=1, immediate ack -> mem_we=1 with mem_req for 1 cycle, mem_wdata=16'h1234, done at start+2, MDRout unchanged.
REQ-038 Timeout: TIMEOUT=15, load, mem_ack held 0 -> mem_req high 15 cycles, err=1, done pulse, MDRout unchanged; next valid start clears err.
REQ-039 Illegal: MemRead=MemWrite=1 with start -> mem_req never asserted, err=1, done pulse next cycle.
REQ-040 Reset mid-ACCESS on 2nd wait cycle -> next cycle mem_req=0, busy=0, no done pulse, all outputs at reset values.
REQ-041 start pulsed during ACCESS, and mem_ack pulsed in IDLE -> both ignored, exactly one done pulse per accepted start.

Source files
------------

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access pipeline stage. A one-cycle start pulse launches a single
// load or store on a simple req/ack memory port. The stage then waits up to
// TIMEOUT cycles for the acknowledge and finishes with a one-cycle done pulse.
//
// Parameters
//   TIMEOUT       maximum ACCESS cycles spent waiting for mem_ack (1..255)
//
// Ports
//   CLK           clock; every state update happens on its rising edge
//   reset         synchronous, active-high reset
//   start         one-cycle request to begin an operation (only seen in IDLE)
//   MemRead       selects a load; sampled together with start
//   MemWrite      selects a store; sampled together with start
//   ALUoutputVal  byte address, passed through unmodified
//   reggieOut     store data
//   mem_rdata     memory read data, valid while mem_ack=1
//   mem_ack       memory completion handshake (only seen in ACCESS)
//   mem_addr      latched address
//   mem_wdata     latched store data
//   mem_req       high for every ACCESS cycle
//   mem_we        high together with mem_req when a store is in progress
//   MDRout        memory data register, holds the result of the last load
//   busy          high whenever the stage is not idle
//   done          one-cycle completion pulse
//   err           sticky error flag (illegal request or timeout)
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [15:0] ALUoutputVal,
  input  logic [15:0] reggieOut,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] MDRout,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] mdr_q, mdr_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      mdr_q   <= 16'h0000;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mdr_q   <= mdr_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mdr_d   = mdr_q;
    we_d    = we_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (MemRead ^ MemWrite) begin
            // Legal request: capture the operands and open a fresh access.
            addr_d  = ALUoutputVal;
            wdata_d = reggieOut;
            we_d    = MemWrite;
            err_d   = 1'b0;
            cnt_d   = 8'h00;
            state_d = ACCESS;
          end else if (MemRead && MemWrite) begin
            // Contradictory request: skip the memory entirely, report it.
            err_d   = 1'b1;
            state_d = DONE;
          end
          // Neither strobe set: the request is dropped and we stay idle.
        end
      end

      ACCESS: begin
        // Acknowledge is checked first so an ack arriving on the very cycle
        // the counter would expire still completes successfully.
        if (mem_ack) begin
          if (!we_q) begin
            mdr_d = mem_rdata;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_C) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: registers or pure decodes of the current state
  // ---------------------------------------------------------------------------
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign MDRout    = mdr_q;
  assign err       = err_q;
  assign mem_req   = (state_q == ACCESS);
  assign mem_we    = (state_q == ACCESS) && we_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//
// Directed and randomized checks of mem_access_stage against a
// transaction-level model: each operation's expected outcome (number of
// request cycles, final error flag, data register content) is computed up
// front from the operation kind and the acknowledge delay.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int TO = 15;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] ALUoutputVal;
  logic [15:0] reggieOut;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] MDRout;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (architectural view only)
  logic [15:0] m_addr, m_wdata, m_mdr;
  logic        m_err;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .start        (start),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .ALUoutputVal (ALUoutputVal),
    .reggieOut    (reggieOut),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .MDRout       (MDRout),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},  {15'd0, busy},    16'd0);
    check({tag, ".done"},  {15'd0, done},    16'd0);
    check({tag, ".req"},   {15'd0, mem_req}, 16'd0);
    check({tag, ".we"},    {15'd0, mem_we},  16'd0);
    check({tag, ".err"},   {15'd0, err},     {15'd0, m_err});
    check({tag, ".mdr"},   MDRout,           m_mdr);
    check({tag, ".addr"},  mem_addr,         m_addr);
    check({tag, ".wdata"}, mem_wdata,        m_wdata);
  endtask

  // kind: 0 = load, 1 = store, 2 = both strobes (illegal)
  // ack_delay: number of ACCESS cycles without ack before ack is raised
  // poke: pulse a stray start in ACCESS/DONE and a stray ack in IDLE
  task automatic run_op(input string tag, input int kind, input logic [15:0] addr,
                        input logic [15:0] wd, input int ack_delay,
                        input logic [15:0] rd, input bit poke);
    int  n_req;
    bit  ok;
    // Expected outcome from the rules alone
    ok    = (ack_delay < TO);
    n_req = ok ? ack_delay + 1 : TO;

    ALUoutputVal = addr;
    reggieOut    = wd;
    MemRead      = (kind != 1);
    MemWrite     = (kind != 0);
    mem_ack      = 1'b0;
    start        = 1'b1;
    @(negedge CLK);
    start = 1'b0;

    if (kind == 2) begin
      m_err = 1'b1;
      check({tag, ".ill.req"},  {15'd0, mem_req}, 16'd0);
      check({tag, ".ill.done"}, {15'd0, done},    16'd1);
      check({tag, ".ill.err"},  {15'd0, err},     16'd1);
    end else begin
      m_addr  = addr;
      m_wdata = wd;
      m_err   = 1'b0;
      for (int c = 1; c <= n_req; c++) begin
        check({tag, ".req"},   {15'd0, mem_req}, 16'd1);
        check({tag, ".we"},    {15'd0, mem_we},  {15'd0, kind == 1});
        check({tag, ".busy"},  {15'd0, busy},    16'd1);
        check({tag, ".done"},  {15'd0, done},    16'd0);
        check({tag, ".addr"},  mem_addr,         m_addr);
        check({tag, ".wdata"}, mem_wdata,        m_wdata);
        mem_ack   = ok && (c == n_req);
        mem_rdata = mem_ack ? rd : 16'($urandom);
        if (poke && c == 2) begin
          start        = 1'b1;
          MemRead      = 1'b1;
          MemWrite     = 1'b0;
          ALUoutputVal = 16'($urandom);
        end
        @(negedge CLK);
        start   = 1'b0;
        mem_ack = 1'b0;
      end
      if (!ok) m_err = 1'b1;
      else if (kind == 0) m_mdr = rd;
      check({tag, ".done"}, {15'd0, done},    16'd1);
      check({tag, ".req"},  {15'd0, mem_req}, 16'd0);
      check({tag, ".err"},  {15'd0, err},     {15'd0, m_err});
      check({tag, ".mdr"},  MDRout,           m_mdr);
    end

    // Stray start while still busy in DONE must not be queued
    if (poke) begin
      start    = 1'b1;
      MemRead  = 1'b0;
      MemWrite = 1'b1;
    end
    @(negedge CLK);
    start = 1'b0;
    check_idle({tag, ".end"});

    // Stray acknowledge while idle must be ignored
    if (poke) begin
      mem_ack   = 1'b1;
      mem_rdata = 16'($urandom);
      @(negedge CLK);
      mem_ack = 1'b0;
      check_idle({tag, ".stray_ack"});
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    ALUoutputVal = 16'h0; reggieOut = 16'h0; mem_rdata = 16'h0; mem_ack = 1'b0;
    m_addr = 16'h0; m_wdata = 16'h0; m_mdr = 16'h0; m_err = 1'b0;

    // Reset must dominate a start and an ack on the same edge
    repeat (2) @(negedge CLK);
    start = 1'b1; MemRead = 1'b1; mem_ack = 1'b1;
    @(negedge CLK);
    start = 1'b0; MemRead = 1'b0; mem_ack = 1'b0;
    reset = 1'b0;
    check_idle("reset");

    // Load, ack on the 3rd ACCESS cycle
    run_op("load_beef", 0, 16'h0040, 16'h5555, 2, 16'hBEEF, 1'b0);
    // Store, immediate ack
    run_op("store_1234", 1, 16'h0102, 16'h1234, 0, 16'hDEAD, 1'b0);
    // Timeout on a load; err must be sticky until the next accepted start
    run_op("timeout", 0, 16'h0200, 16'h0000, 100, 16'hAAAA, 1'b0);
    // Start with neither strobe: ignored, err stays set
    start = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    check_idle("no_strobe");
    // Ack exactly on the last allowed cycle counts as success and clears err
    run_op("ack_at_limit", 0, 16'h0301, 16'h0000, TO - 1, 16'h7E57, 1'b0);
    // Ack one cycle too late is a timeout
    run_op("ack_too_late", 0, 16'h0302, 16'h0000, TO, 16'h1111, 1'b0);
    // Illegal request
    run_op("illegal", 2, 16'h0400, 16'h9999, 0, 16'h0000, 1'b0);
    // Stray start in ACCESS/DONE and stray ack in IDLE
    run_op("stray", 0, 16'h0500, 16'h0000, 3, 16'hC0DE, 1'b1);

    // Reset on the 2nd wait cycle of an access
    ALUoutputVal = 16'h0600; MemRead = 1'b1; MemWrite = 1'b0; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    check("rst_mid.req_before", {15'd0, mem_req}, 16'd1);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    m_addr = 16'h0; m_wdata = 16'h0; m_mdr = 16'h0; m_err = 1'b0;
    check_idle("rst_mid");
    @(negedge CLK);
    check("rst_mid.no_done", {15'd0, done}, 16'd0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      int k;
      k = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", i), k, 16'($urandom), 16'($urandom),
             int'($urandom_range(0, TO + 2)), 16'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
